pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/barrel_shifter_pkg.sv | 14 +
 rtl/barrel_shifter_stage.sv | 82 ++++++++
 rtl/pipelined_barrel_shifter.sv | 70 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared mode encodings for the barrel shifter family.
// Imported by the RTL and by the 32-bit shifter benches.
package barrel_shifter_pkg;

   localparam logic [2:0] MODE_LSL = 3'd0;
   localparam logic [2:0] MODE_LSR = 3'd1;
   localparam logic [2:0] MODE_ASL = 3'd2;
   localparam logic [2:0] MODE_ASR = 3'd3;
   localparam logic [2:0] MODE_ROL = 3'd4;
   localparam logic [2:0] MODE_ROR = 3'd5;
   localparam logic [2:0] MODE_RCL = 3'd6;
   localparam logic [2:0] MODE_RCR = 3'd7;

endpackage

// File: rtl/barrel_shifter_stage.sv
// One registered pipeline stage: shifts or rotates by 2**STAGE_INDEX when
// amount bit STAGE_INDEX is set, and forwards mode/amount/carry with the beat.
module barrel_shifter_stage
   import barrel_shifter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGE_INDEX = 0,
   localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   advance,
   input  logic                   src_valid,
   input  logic [2:0]             src_mode,
   input  logic [SHIFT_WIDTH-1:0] src_amount,
   input  logic                   src_carry,
   input  logic [DATA_WIDTH-1:0]  src_data,
   output logic                   valid_reg,
   output logic [2:0]             mode_reg,
   output logic [SHIFT_WIDTH-1:0] amount_reg,
   output logic                   carry_reg,
   output logic [DATA_WIDTH-1:0]  data_reg
);

   localparam int SHIFT = 1 << STAGE_INDEX;

   logic [DATA_WIDTH:0]   ring;
   logic [DATA_WIDTH-1:0] data_next;
   logic                  carry_next;

   assign ring = {src_carry, src_data};

   always_comb begin
      data_next  = src_data;
      carry_next = src_carry;
      if (src_amount[STAGE_INDEX]) begin
         case (src_mode)
            MODE_LSL, MODE_ASL: begin
               data_next  = {src_data[DATA_WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
               carry_next = src_data[DATA_WIDTH-SHIFT];
            end
            MODE_LSR: begin
               data_next  = {{SHIFT{1'b0}}, src_data[DATA_WIDTH-1:SHIFT]};
               carry_next = src_data[SHIFT-1];
            end
            MODE_ASR: begin
               data_next  = {{SHIFT{src_data[DATA_WIDTH-1]}}, src_data[DATA_WIDTH-1:SHIFT]};
               carry_next = src_data[SHIFT-1];
            end
            // Rotate carry tracks the bit that ends up at the LSB / MSB of the result.
            MODE_ROL: begin
               data_next  = {src_data[DATA_WIDTH-1-SHIFT:0], src_data[DATA_WIDTH-1:DATA_WIDTH-SHIFT]};
               carry_next = src_data[DATA_WIDTH-SHIFT];
            end
            MODE_ROR: begin
               data_next  = {src_data[SHIFT-1:0], src_data[DATA_WIDTH-1:SHIFT]};
               carry_next = src_data[SHIFT-1];
            end
            MODE_RCL: {carry_next, data_next} = {ring[DATA_WIDTH-SHIFT:0], ring[DATA_WIDTH:DATA_WIDTH-SHIFT+1]};
            MODE_RCR: {carry_next, data_next} = {ring[SHIFT-1:0], ring[DATA_WIDTH:SHIFT]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg  <= 1'b0;
         mode_reg   <= '0;
         amount_reg <= '0;
         carry_reg  <= 1'b0;
         data_reg   <= '0;
      end else if (advance) begin
         valid_reg  <= src_valid;
         mode_reg   <= src_mode;
         amount_reg <= src_amount;
         carry_reg  <= carry_next;
         data_reg   <= data_next;
      end
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Linear log2(DATA_WIDTH)-stage shift/rotate pipeline with valid/ready flow
// control; the whole pipeline freezes while the output beat is stalled.
module pipelined_barrel_shifter
   import barrel_shifter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   Clock_In,
   input  logic                   Reset_In,
   input  logic                   In_Valid,
   output logic                   In_Ready,
   input  logic [2:0]             Shifter_Mode_In,
   input  logic [SHIFT_WIDTH-1:0] Shift_Bits_Length_In,
   input  logic                   Carry_In,
   input  logic [DATA_WIDTH-1:0]  Data_In,
   output logic                   Out_Valid,
   input  logic                   Out_Ready,
   output logic [DATA_WIDTH-1:0]  Shifted_Data_Out,
   output logic                   Carry_Out
);

   logic [SHIFT_WIDTH:0]                  valid_pipe;
   logic [SHIFT_WIDTH:0][2:0]             mode_pipe;
   logic [SHIFT_WIDTH:0][SHIFT_WIDTH-1:0] amount_pipe;
   logic [SHIFT_WIDTH:0]                  carry_pipe;
   logic [SHIFT_WIDTH:0][DATA_WIDTH-1:0]  data_pipe;
   logic                                  stall;
   logic                                  unused_tail;

   assign stall    = Out_Valid & ~Out_Ready;
   assign In_Ready = ~stall & ~Reset_In;

   assign valid_pipe[0]  = In_Valid & In_Ready;
   assign mode_pipe[0]   = Shifter_Mode_In;
   assign amount_pipe[0] = Shift_Bits_Length_In;
   assign carry_pipe[0]  = Carry_In;
   assign data_pipe[0]   = Data_In;

   // Bubbles advance with the pipeline; nothing moves while stalled.
   generate
      for (genvar gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_stage
         barrel_shifter_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGE_INDEX(gi)
         ) u_stage (
            .clk       (Clock_In),
            .srst      (Reset_In),
            .advance   (~stall),
            .src_valid (valid_pipe[gi]),
            .src_mode  (mode_pipe[gi]),
            .src_amount(amount_pipe[gi]),
            .src_carry (carry_pipe[gi]),
            .src_data  (data_pipe[gi]),
            .valid_reg (valid_pipe[gi+1]),
            .mode_reg  (mode_pipe[gi+1]),
            .amount_reg(amount_pipe[gi+1]),
            .carry_reg (carry_pipe[gi+1]),
            .data_reg  (data_pipe[gi+1])
         );
      end
   endgenerate

   assign Out_Valid        = valid_pipe[SHIFT_WIDTH];
   assign Shifted_Data_Out = data_pipe[SHIFT_WIDTH];
   assign Carry_Out        = carry_pipe[SHIFT_WIDTH];

   assign unused_tail = ^{mode_pipe[SHIFT_WIDTH], amount_pipe[SHIFT_WIDTH]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (DATA_WIDTH = 32): directed
// vector table, stall/reset sequences and random traffic against a reference model.
module tb_pipelined_barrel_shifter;
   import barrel_shifter_pkg::*;

   logic        Clock_In = 1'b0;
   logic        Reset_In = 1'b1;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [2:0]  Shifter_Mode_In = '0;
   logic [4:0]  Shift_Bits_Length_In = '0;
   logic        Carry_In = 1'b0;
   logic [31:0] Data_In = '0;
   logic        Out_Valid;
   logic        Out_Ready = 1'b1;
   logic [31:0] Shifted_Data_Out;
   logic        Carry_Out;

   int checks = 0;
   int errors = 0;
   int out_count = 0;
   logic [32:0] exp_q[$];
   logic        held_valid = 1'b0;
   logic [32:0] held_value = '0;

   typedef struct {
      logic [2:0]  mode;
      logic [4:0]  amt;
      logic        cin;
      logic [31:0] din;
      logic [31:0] dout;
      logic        cout;
   } vec_t;
   vec_t vecs[$];

   pipelined_barrel_shifter #(.DATA_WIDTH(32)) dut (
      .Clock_In            (Clock_In),
      .Reset_In            (Reset_In),
      .In_Valid            (In_Valid),
      .In_Ready            (In_Ready),
      .Shifter_Mode_In     (Shifter_Mode_In),
      .Shift_Bits_Length_In(Shift_Bits_Length_In),
      .Carry_In            (Carry_In),
      .Data_In             (Data_In),
      .Out_Valid           (Out_Valid),
      .Out_Ready           (Out_Ready),
      .Shifted_Data_Out    (Shifted_Data_Out),
      .Carry_Out           (Carry_Out)
   );

   always #5 Clock_In = ~Clock_In;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole-amount shifts/rotates on the operand (or the 33-bit carry ring).
   function automatic logic [32:0] ref_model(input logic [2:0] mode, input int n,
                                             input logic c, input logic [31:0] d);
      logic [31:0] r;
      logic [32:0] rg;
      if (n == 0) return {c, d};
      rg = {c, d};
      case (mode)
         MODE_LSL, MODE_ASL: begin r = d << n; return {d[32-n], r}; end
         MODE_LSR: begin r = d >> n; return {d[n-1], r}; end
         MODE_ASR: begin r = $signed(d) >>> n; return {d[n-1], r}; end
         MODE_ROL: begin r = (d << n) | (d >> (32-n)); return {r[0], r}; end
         MODE_ROR: begin r = (d >> n) | (d << (32-n)); return {r[31], r}; end
         MODE_RCL: return (rg << n) | (rg >> (33-n));
         default:  return (rg >> n) | (rg << (33-n));
      endcase
   endfunction

   // Scoreboard and protocol monitor, sampled mid-cycle.
   always @(negedge Clock_In) begin
      logic [32:0] e;
      if (Reset_In) begin
         exp_q.delete();
         held_valid = 1'b0;
         check("reset_in_ready", In_Ready, 0);
      end else begin
         check("in_ready_rule", In_Ready, !(Out_Valid && !Out_Ready));
         if (held_valid) begin
            check("hold_valid", Out_Valid, 1);
            check("hold_value", {Carry_Out, Shifted_Data_Out}, held_value);
         end
         held_valid = Out_Valid && !Out_Ready;
         held_value = {Carry_Out, Shifted_Data_Out};
         if (In_Valid && In_Ready)
            exp_q.push_back(ref_model(Shifter_Mode_In, int'(Shift_Bits_Length_In), Carry_In, Data_In));
         if (Out_Valid && Out_Ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", {Carry_Out, Shifted_Data_Out}, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("result", {Carry_Out, Shifted_Data_Out}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock_In);
      #1;
   endtask

   task automatic randomize_inputs();
      Shifter_Mode_In      = 3'($urandom_range(0, 7));
      Shift_Bits_Length_In = 5'($urandom_range(0, 31));
      Carry_In             = 1'($urandom_range(0, 1));
      Data_In              = $urandom();
   endtask

   initial begin
      int lat;
      int sent;
      int base;
      bit acc;

      vecs.push_back('{MODE_LSL, 5'd4, 1'b0, 32'h1000_000F, 32'h0000_00F0, 1'b1});
      vecs.push_back('{MODE_ASR, 5'd8, 1'b0, 32'h8000_0100, 32'hFF80_0001, 1'b0});
      vecs.push_back('{MODE_ROR, 5'd4, 1'b0, 32'h0000_000A, 32'hA000_0000, 1'b1});
      vecs.push_back('{MODE_RCR, 5'd1, 1'b1, 32'h0000_0001, 32'h8000_0000, 1'b1});
      vecs.push_back('{MODE_RCL, 5'd1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1});
      vecs.push_back('{MODE_LSL, 5'd31, 1'b0, 32'h0000_0003, 32'h8000_0000, 1'b1});
      vecs.push_back('{MODE_LSR, 5'd31, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0});
      vecs.push_back('{MODE_ROL, 5'd8, 1'b0, 32'h1234_5678, 32'h3456_7812, 1'b0});
      for (int m = 0; m < 8; m++)
         vecs.push_back('{3'(m), 5'd0, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1});

      // Reset state
      repeat (3) tick();
      check("in_ready_during_reset", In_Ready, 0);
      Reset_In = 1'b0;
      #1;
      check("in_ready_after_reset", In_Ready, 1);
      check("out_valid_after_reset", Out_Valid, 0);
      check("data_after_reset", Shifted_Data_Out, 0);
      check("carry_after_reset", Carry_Out, 0);

      // Directed vectors with latency measurement; idle inputs are scrambled
      for (int i = 0; i < vecs.size(); i++) begin
         Shifter_Mode_In      = vecs[i].mode;
         Shift_Bits_Length_In = vecs[i].amt;
         Carry_In             = vecs[i].cin;
         Data_In              = vecs[i].din;
         In_Valid             = 1'b1;
         Out_Ready            = 1'b1;
         tick();
         In_Valid = 1'b0;
         lat = 1;
         while (!Out_Valid && lat < 20) begin
            randomize_inputs();
            tick();
            lat++;
         end
         check($sformatf("vec%0d_latency", i), lat, 5);
         check($sformatf("vec%0d_data", i), Shifted_Data_Out, vecs[i].dout);
         check($sformatf("vec%0d_carry", i), Carry_Out, vecs[i].cout);
         $display("vec%0d mode=%0d amt=%0d cin=%0d din=%h -> dout=%h cout=%0d",
                  i, vecs[i].mode, vecs[i].amt, vecs[i].cin, vecs[i].din, Shifted_Data_Out, Carry_Out);
         tick();
      end

      // Eight back-to-back beats with a three-cycle output stall
      sent = 0;
      base = out_count;
      for (int cyc = 0; cyc < 60; cyc++) begin
         Out_Ready = !(cyc >= 6 && cyc < 9);
         In_Valid  = (sent < 8);
         randomize_inputs();
         @(negedge Clock_In);
         acc = In_Valid && In_Ready;
         if (cyc >= 6 && cyc < 9) begin
            check("stall_in_ready", In_Ready, 0);
            check("stall_out_valid", Out_Valid, 1);
         end
         tick();
         if (acc) sent++;
         if (sent == 8 && out_count - base == 8) break;
      end
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      check("stall_beats_sent", sent, 8);
      check("stall_beats_out", out_count - base, 8);
      check("stall_queue_empty", exp_q.size(), 0);
      $display("stall sequence: sent=%0d received=%0d", sent, out_count - base);

      // Reset with three beats in flight
      Out_Ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         In_Valid = 1'b1;
         randomize_inputs();
         tick();
      end
      In_Valid = 1'b0;
      Reset_In = 1'b1;
      #1;
      check("midreset_in_ready", In_Ready, 0);
      tick();
      Reset_In = 1'b0;
      #1;
      check("midreset_out_valid", Out_Valid, 0);
      check("midreset_data", Shifted_Data_Out, 0);
      check("midreset_carry", Carry_Out, 0);
      check("midreset_in_ready_after", In_Ready, 1);
      base = out_count;
      repeat (15) tick();
      check("midreset_no_stale", out_count - base, 0);
      $display("mid-flight reset: outputs after reset=%0d", out_count - base);

      // Random traffic with random backpressure
      for (int cyc = 0; cyc < 400; cyc++) begin
         In_Valid  = ($urandom_range(0, 3) != 0);
         Out_Ready = ($urandom_range(0, 3) != 0);
         randomize_inputs();
         tick();
      end
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      lat = 0;
      while ((exp_q.size() != 0 || Out_Valid) && lat < 50) begin
         tick();
         lat++;
      end
      check("random_drain", exp_q.size(), 0);
      $display("random traffic: total outputs=%0d", out_count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
